// File: rtl/audio_pkg.sv
// audio_pkg
//   Shared constants and types for the codec audio path.
//   AUD_WL           default PCM word length per channel (bits)
//   AUD_PKT_SAMPLES  default number of stereo pairs per Ethernet audio packet
//   LRC_LEFT         level of the codec LR clock during the left half-frame
//   sync_state_t     framing states of the I2S receiver

package audio_pkg;

   localparam int   AUD_WL          = 32;
   localparam int   AUD_PKT_SAMPLES = 256;
   localparam logic LRC_LEFT        = 1'b0;

   // SYNC_HUNT      : no 1->0 LR edge seen since reset, everything is discarded
   // SYNC_WAIT_LEFT : framed, waiting for the left half to finish
   // SYNC_HAVE_LEFT : left word held, the next 1->0 edge completes the pair
   typedef enum logic [1:0] {
      SYNC_HUNT      = 2'd0,
      SYNC_WAIT_LEFT = 2'd1,
      SYNC_HAVE_LEFT = 2'd2
   } sync_state_t;

endpackage

// File: rtl/audio_i2s_rx.sv
// audio_i2s_rx
//   I2S capture stage for the codec ADC path. Deserialises the serial ADC
//   stream into left/right PCM words and presents one stereo pair per frame
//   with a single-cycle done strobe, together with the pair index inside the
//   current Ethernet audio packet and a last-pair flag.
//
//   aud_bclk    in   codec bit clock, all logic on its rising edge
//   rst_n       in   asynchronous active-low reset
//   aud_lrc     in   codec LR clock, 0 = left half, 1 = right half
//   aud_adcdat  in   serial ADC data, MSB first, one bclk after the LR edge
//   aud_left    out  captured left word
//   aud_right   out  captured right word
//   rx_done     out  one-cycle strobe, aud_left/aud_right hold a new pair
//   frm_err     out  with rx_done: one of the halves carried fewer than WL bits
//   sample_cnt  out  index of the delivered pair inside its packet
//   pkt_last    out  with rx_done: the pair is the last one of a packet

module audio_i2s_rx
   import audio_pkg::*;
#(
   parameter int WL          = AUD_WL,
   parameter int PKT_SAMPLES = AUD_PKT_SAMPLES
) (
   input  logic                           aud_bclk,
   input  logic                           rst_n,
   input  logic                           aud_lrc,
   input  logic                           aud_adcdat,
   output logic [WL-1:0]                  aud_left,
   output logic [WL-1:0]                  aud_right,
   output logic                           rx_done,
   output logic                           frm_err,
   output logic [$clog2(PKT_SAMPLES)-1:0] sample_cnt,
   output logic                           pkt_last
);

   localparam int BCW = $clog2(WL + 1);
   localparam int CW  = $clog2(PKT_SAMPLES);

   logic                lrc_d1;
   logic                lrc_edge;
   logic                lrc_rise;
   logic                lrc_fall;
   logic [WL-1:0]       sr;
   logic [WL-1:0]       cap_word;
   logic [WL-1:0]       half_word;
   logic                half_short;
   logic                bit_room;
   logic [BCW-1:0]      bit_cnt;
   logic [WL-1:0]       left_hold;
   logic                left_short;
   logic [CW-1:0]       pair_idx;
   logic                pair_wrap;
   sync_state_t         state;
   sync_state_t         next_state;
   logic                load_left;
   logic                deliver;

   // LR edge detection against the previous cycle's LR level
   always_ff @(posedge aud_bclk or negedge rst_n) begin
      if (!rst_n) begin
         lrc_d1 <= 1'b0;
      end else begin
         lrc_d1 <= aud_lrc;
      end
   end

   assign lrc_edge = (aud_lrc != lrc_d1);
   assign lrc_rise = lrc_edge && (aud_lrc != LRC_LEFT);
   assign lrc_fall = lrc_edge && (aud_lrc == LRC_LEFT);
   assign bit_room = (bit_cnt < BCW'(WL));

   // Shift register contents including the bit arriving this cycle. On an LR
   // edge this bit still belongs to the ending half (I2S one-bclk delay), so
   // the half word seen at the edge is taken from here. A half that ends
   // before any bit was collected reads as all zeros.
   always_comb begin
      cap_word = sr;
      for (int i = 0; i < WL; i++) begin
         if (bit_room && (BCW'(WL - 1 - i) == bit_cnt)) begin
            cap_word[i] = aud_adcdat;
         end
      end
      half_word  = (bit_cnt == '0) ? '0 : cap_word;
      half_short = (bit_cnt < BCW'(WL - 1));
   end

   // Capture shift register and saturating bit counter, restarted at every LR edge
   always_ff @(posedge aud_bclk or negedge rst_n) begin
      if (!rst_n) begin
         sr      <= '0;
         bit_cnt <= '0;
      end else if (lrc_edge) begin
         sr      <= '0;
         bit_cnt <= '0;
      end else begin
         sr <= cap_word;
         if (bit_room) begin
            bit_cnt <= bit_cnt + BCW'(1);
         end
      end
   end

   // Framing state register
   always_ff @(posedge aud_bclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SYNC_HUNT;
      end else begin
         state <= next_state;
      end
   end

   // Framing next state: the first falling LR edge only establishes framing
   always_comb begin
      next_state = state;
      case (state)
         SYNC_HUNT: begin
            if (lrc_fall) next_state = SYNC_WAIT_LEFT;
         end
         SYNC_WAIT_LEFT: begin
            if (lrc_rise) next_state = SYNC_HAVE_LEFT;
         end
         SYNC_HAVE_LEFT: begin
            if (lrc_fall) next_state = SYNC_WAIT_LEFT;
         end
         default: next_state = SYNC_HUNT;
      endcase
   end

   // Framing outputs: when to latch the left word and when to emit a pair
   always_comb begin
      load_left = 1'b0;
      deliver   = 1'b0;
      case (state)
         SYNC_WAIT_LEFT: load_left = lrc_rise;
         SYNC_HAVE_LEFT: begin
            load_left = lrc_rise;
            deliver   = lrc_fall;
         end
         default: begin
            load_left = 1'b0;
            deliver   = 1'b0;
         end
      endcase
   end

   // Left word is parked here until its right partner completes
   always_ff @(posedge aud_bclk or negedge rst_n) begin
      if (!rst_n) begin
         left_hold  <= '0;
         left_short <= 1'b0;
      end else if (load_left) begin
         left_hold  <= half_word;
         left_short <= half_short;
      end
   end

   assign pair_wrap = (pair_idx == CW'(PKT_SAMPLES - 1));

   // Pair delivery and packet position; strobes last exactly one cycle
   always_ff @(posedge aud_bclk or negedge rst_n) begin
      if (!rst_n) begin
         aud_left   <= '0;
         aud_right  <= '0;
         rx_done    <= 1'b0;
         frm_err    <= 1'b0;
         pkt_last   <= 1'b0;
         sample_cnt <= '0;
         pair_idx   <= '0;
      end else begin
         rx_done  <= deliver;
         frm_err  <= deliver && (left_short || half_short);
         pkt_last <= deliver && pair_wrap;
         if (deliver) begin
            aud_left   <= left_hold;
            aud_right  <= half_word;
            sample_cnt <= pair_idx;
            pair_idx   <= pair_wrap ? '0 : pair_idx + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_audio_i2s_rx.sv
// tb_audio_i2s_rx
//   Drives I2S frames (directed and random) into two receiver instances:
//   a WL=32 / 4-pair-packet instance for the main sequence and a WL=16
//   instance for the tied-high data phase. Expected pairs come from a
//   frame-level model of what the codec sent.

module tb_audio_i2s_rx;

   localparam int WL32  = 32;
   localparam int PKT32 = 4;
   localparam int WL16  = 16;
   localparam int PKT16 = 256;

   logic        aud_bclk = 1'b0;
   logic        rst_n;
   logic        aud_lrc;
   logic        aud_adcdat;

   logic [31:0] left32;
   logic [31:0] right32;
   logic        done32;
   logic        err32;
   logic [1:0]  cnt32;
   logic        last32;

   logic [15:0] left16;
   logic [15:0] right16;
   logic        done16;
   logic        err16;
   logic [7:0]  cnt16;
   logic        last16;

   int          errors = 0;
   int          checks = 0;

   // Frame-level model state
   bit          use16;
   int          cur_wl;
   int          cur_pkt;
   bit          synced;
   bit          pend_valid;
   logic [31:0] pend_left;
   logic [31:0] pend_right;
   bit          pend_err;
   int          pair_idx;
   logic        pend_bit;

   audio_i2s_rx #(.WL(WL32), .PKT_SAMPLES(PKT32)) u_dut (
      .aud_bclk   (aud_bclk),
      .rst_n      (rst_n),
      .aud_lrc    (aud_lrc),
      .aud_adcdat (aud_adcdat),
      .aud_left   (left32),
      .aud_right  (right32),
      .rx_done    (done32),
      .frm_err    (err32),
      .sample_cnt (cnt32),
      .pkt_last   (last32)
   );

   audio_i2s_rx #(.WL(WL16), .PKT_SAMPLES(PKT16)) u_dut16 (
      .aud_bclk   (aud_bclk),
      .rst_n      (rst_n),
      .aud_lrc    (aud_lrc),
      .aud_adcdat (aud_adcdat),
      .aud_left   (left16),
      .aud_right  (right16),
      .rx_done    (done16),
      .frm_err    (err16),
      .sample_cnt (cnt16),
      .pkt_last   (last16)
   );

   always #5 aud_bclk = ~aud_bclk;

   function automatic logic [31:0] word_mask(input int wl);
      return (wl >= 32) ? 32'hFFFF_FFFF : ((32'h1 << wl) - 32'h1);
   endfunction

   // What a receiver of width wl should hold after a half of len bclks
   function automatic logic [31:0] exp_word(input logic [31:0] w, input int len, input int wl);
      logic [31:0] m;
      m = word_mask(wl);
      if (len >= wl) return w & m;
      return ((w >> (wl - len)) << (wl - len)) & m;
   endfunction

   // Serial bit p of a half, MSB first; bits beyond the word are surplus
   function automatic logic bit_at(input logic [31:0] w, input int p, input int wl, input logic surplus);
      if (p < wl) return w[wl - 1 - p];
      return surplus;
   endfunction

   function automatic logic [31:0] obs_left();
      return use16 ? {16'h0, left16} : left32;
   endfunction
   function automatic logic [31:0] obs_right();
      return use16 ? {16'h0, right16} : right32;
   endfunction
   function automatic logic obs_done();
      return use16 ? done16 : done32;
   endfunction
   function automatic logic obs_err();
      return use16 ? err16 : err32;
   endfunction
   function automatic logic obs_last();
      return use16 ? last16 : last32;
   endfunction
   function automatic logic [31:0] obs_cnt();
      return use16 ? {24'h0, cnt16} : {30'h0, cnt32};
   endfunction

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic model_reset();
      synced     = 1'b0;
      pend_valid = 1'b0;
      pair_idx   = 0;
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, ".left"},  obs_left(),  32'h0);
      check_output({tag, ".right"}, obs_right(), 32'h0);
      check_output({tag, ".done"},  {31'h0, obs_done()}, 32'h0);
      check_output({tag, ".err"},   {31'h0, obs_err()},  32'h0);
      check_output({tag, ".cnt"},   obs_cnt(),   32'h0);
      check_output({tag, ".last"},  {31'h0, obs_last()}, 32'h0);
   endtask

   // Drive one half-frame of len bclks at LR level lv. A reset pulse of
   // 3 bclk can be inserted starting at cycle rst_at (negative = none).
   task automatic apply_stimulus(input logic lv, input logic [31:0] w, input int len,
                                 input logic surplus, input int rst_at);
      logic exp_done;
      logic exp_last;
      for (int p = 0; p < len; p++) begin
         @(negedge aud_bclk);
         aud_lrc    = lv;
         aud_adcdat = pend_bit;
         pend_bit   = bit_at(w, p, cur_wl, surplus);
         if (rst_at >= 0 && p == rst_at + 3) rst_n = 1'b1;
         if (rst_at >= 0 && p == rst_at) begin
            rst_n = 1'b0;
            model_reset();
            #1;
            check_reset_values("async_rst");
         end
         @(posedge aud_bclk);
         #1;
         exp_done = (p == 0) && (lv == 1'b0) && rst_n && synced && pend_valid;
         exp_last = exp_done && (pair_idx == cur_pkt - 1);
         check_output("rx_done",  {31'h0, obs_done()}, {31'h0, exp_done});
         check_output("pkt_last", {31'h0, obs_last()}, {31'h0, exp_last});
         check_output("frm_err",  {31'h0, obs_err()},  {31'h0, exp_done && pend_err});
         if (exp_done) begin
            check_output("aud_left",   obs_left(),  pend_left);
            check_output("aud_right",  obs_right(), pend_right);
            check_output("sample_cnt", obs_cnt(),   32'(pair_idx));
            pair_idx = (pair_idx + 1) % cur_pkt;
         end
         if (p == 0 && lv == 1'b0 && rst_n) begin
            synced     = 1'b1;
            pend_valid = 1'b0;
         end
      end
   endtask

   task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw, input int ll,
                             input int lr, input logic surplus, input int rst_at);
      apply_stimulus(1'b0, lw, ll, surplus, -1);
      apply_stimulus(1'b1, rw, lr, surplus, rst_at);
      pend_valid = synced;
      pend_left  = exp_word(lw, ll, cur_wl);
      pend_right = exp_word(rw, lr, cur_wl);
      pend_err   = (ll < cur_wl) || (lr < cur_wl);
   endtask

   function automatic int rand_len();
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) return 128;
      if (r <= 2) return int'($urandom_range(17, 31));
      return int'($urandom_range(32, 40));
   endfunction

   initial begin
      use16      = 1'b0;
      cur_wl     = WL32;
      cur_pkt    = PKT32;
      pend_bit   = 1'b0;
      pend_left  = '0;
      pend_right = '0;
      pend_err   = 1'b0;
      model_reset();
      rst_n      = 1'b0;
      aud_lrc    = 1'b1;
      aud_adcdat = 1'b0;

      // Reset state
      repeat (3) @(negedge aud_bclk);
      #1;
      check_reset_values("reset");
      @(negedge aud_bclk);
      rst_n = 1'b1;

      // Partial right half before framing, then the directed frames
      apply_stimulus(1'b1, $urandom, 10, 1'b0, -1);
      send_frame(32'hA5A5_0F0F, 32'h1234_5678, 32, 32, 1'b0, -1);
      send_frame(32'h8000_0001, 32'h7FFF_FFFE, 128, 128, 1'b1, -1);
      send_frame(32'hABCD_EF00, $urandom, 24, 32, 1'b0, -1);

      // Random frames spanning several packets
      for (int f = 0; f < 10; f++) begin
         send_frame($urandom, $urandom, rand_len(), rand_len(), 1'($urandom_range(0, 1)), -1);
      end

      // Reset in the middle of a right half, then resync
      send_frame($urandom, $urandom, 32, 32, 1'b0, 10);
      send_frame($urandom, $urandom, 32, 32, 1'b0, -1);
      send_frame($urandom, $urandom, 32, 32, 1'b0, -1);
      apply_stimulus(1'b0, $urandom, 32, 1'b0, -1);

      // WL=16 instance with data tied high
      @(negedge aud_bclk);
      rst_n    = 1'b0;
      use16    = 1'b1;
      cur_wl   = WL16;
      cur_pkt  = PKT16;
      aud_lrc  = 1'b1;
      pend_bit = 1'b1;
      model_reset();
      repeat (2) @(negedge aud_bclk);
      #1;
      check_reset_values("reset16");
      @(negedge aud_bclk);
      rst_n = 1'b1;
      apply_stimulus(1'b1, 32'h0000_FFFF, 8, 1'b1, -1);
      for (int f = 0; f < 4; f++) begin
         send_frame(32'h0000_FFFF, 32'h0000_FFFF, 16, 16, 1'b1, -1);
      end
      apply_stimulus(1'b0, 32'h0000_FFFF, 16, 1'b1, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
